// File: rtl/blink_pkg.sv
// Shared types and defaults for the LED blink detector.
package blink_pkg;

   // Acquisition state of the detector.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACQ  = 2'd1,
      LOCK = 2'd2
   } state_t;

   // Default log2 of the expected half-period in clk cycles.
   localparam int DEF_CBITS    = 20;
   // Default accepted deviation in cycles, either side of the half-period.
   localparam int DEF_TOL      = 4;
   // Default number of consecutive good intervals needed to lock.
   localparam int DEF_LOCK_CNT = 3;

endpackage

// File: rtl/blink_sync.sv
// Two-flop synchronizer for the asynchronous led input, plus a history
// flop so that transitions of the synchronized value can be detected.
module blink_sync (
   input  logic clk,
   input  logic rst,
   input  logic led,
   output logic level,
   output logic edge_det
);

   logic s1;
   logic s2;
   logic hist;

   // Synchronizer chain and one-cycle history of its output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         hist <= 1'b0;
      end else begin
         s1   <= led;
         s2   <= s1;
         hist <= s2;
      end
   end

   assign level    = s2;
   // High for exactly one cycle whenever the synchronized value changes.
   assign edge_det = s2 ^ hist;

endmodule

// File: rtl/blink_detector.sv
// Blink detector: measures the interval between led transitions and
// declares lock once enough consecutive intervals sit within HALF+/-TOL.
// A missing edge (interval counter saturating) drops back to IDLE.
// fsm_state mirrors the internal state for observation.
module blink_detector
   import blink_pkg::*;
#(
   parameter int CBITS    = DEF_CBITS,
   parameter int TOL      = DEF_TOL,
   parameter int LOCK_CNT = DEF_LOCK_CNT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             led,
   output logic             level,
   output logic             edge_p,
   output logic [CBITS+1:0] period,
   output logic             locked,
   output logic             err,
   output logic [1:0]       fsm_state
);

   localparam int W    = CBITS + 2;
   localparam int GW   = $clog2(LOCK_CNT + 1);
   localparam int HALF = 2 ** CBITS;

   // Window bounds and the saturation value (one past the upper bound,
   // which doubles as the timeout threshold).
   localparam logic [W-1:0]  LO_V   = W'(HALF - TOL);
   localparam logic [W-1:0]  HI_V   = W'(HALF + TOL);
   localparam logic [W-1:0]  SAT_V  = W'(HALF + TOL + 1);
   localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CNT);

   state_t        state;
   logic [W-1:0]  ivl;
   logic [GW-1:0] good;
   logic [GW-1:0] good_inc;
   logic          edge_det;
   logic          ivl_good;
   logic          timeout;

   blink_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .led      (led),
      .level    (level),
      .edge_det (edge_det)
   );

   assign ivl_good  = (ivl >= LO_V) && (ivl <= HI_V);
   // An edge arriving on the saturation cycle takes priority over timeout.
   assign timeout   = !edge_det && (ivl == SAT_V);
   assign good_inc  = good + 1'b1;
   assign fsm_state = state;

   // Registered copy of the edge strobe for the output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         edge_p <= 1'b0;
      end else begin
         edge_p <= edge_det;
      end
   end

   // Interval counter: restarts at 1 on each edge, saturates otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ivl <= '0;
      end else if (edge_det) begin
         ivl <= W'(1);
      end else if (ivl != SAT_V) begin
         ivl <= ivl + 1'b1;
      end
   end

   // Acquisition FSM with registered period, locked and err outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         good   <= '0;
         period <= '0;
         locked <= 1'b0;
         err    <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               // The first edge only starts a measurement; no interval yet.
               if (edge_det) begin
                  state <= ACQ;
                  good  <= '0;
               end
            end
            ACQ: begin
               if (edge_det) begin
                  period <= ivl;
                  if (ivl_good) begin
                     good <= good_inc;
                     if (good_inc == LOCK_V) begin
                        state  <= LOCK;
                        locked <= 1'b1;
                     end
                  end else begin
                     err  <= 1'b1;
                     good <= '0;
                  end
               end else if (timeout) begin
                  err    <= 1'b1;
                  good   <= '0;
                  locked <= 1'b0;
                  state  <= IDLE;
               end
            end
            LOCK: begin
               if (edge_det) begin
                  period <= ivl;
                  if (!ivl_good) begin
                     err    <= 1'b1;
                     good   <= '0;
                     locked <= 1'b0;
                     state  <= ACQ;
                  end
               end else if (timeout) begin
                  err    <= 1'b1;
                  good   <= '0;
                  locked <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               state  <= IDLE;
               good   <= '0;
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_blink_detector.sv
// Directed bench for blink_detector at CBITS=4 (HALF=16), TOL=1, LOCK_CNT=3.
module tb_blink_detector;
   import blink_pkg::*;

   logic       clk;
   logic       rst;
   logic       led;
   logic       level;
   logic       edge_p;
   logic [5:0] period;
   logic       locked;
   logic       err;
   logic [1:0] fsm_state;

   int n_checks;
   int n_errors;
   int err_cnt;

   blink_detector #(
      .CBITS    (4),
      .TOL      (1),
      .LOCK_CNT (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .led       (led),
      .level     (level),
      .edge_p    (edge_p),
      .period    (period),
      .locked    (locked),
      .err       (err),
      .fsm_state (fsm_state)
   );

   // Clock and err pulse counter (one count per high cycle).
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst && err) err_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Toggle led, check the edge response three cycles later (evaluation of
   // the previous half-period), then finish a half-period of len cycles.
   task automatic half_chk(input string tag, input int len, input logic exp_err,
                           input logic exp_locked, input logic [1:0] exp_state,
                           input int exp_period);
      led = ~led;
      tick();
      tick();
      chk({tag, ":edge_early"}, edge_p, 0);
      chk({tag, ":level"}, level, led);
      tick();
      chk({tag, ":edge_p"}, edge_p, 1);
      chk({tag, ":err"}, err, exp_err);
      chk({tag, ":locked"}, locked, exp_locked);
      chk({tag, ":state"}, fsm_state, exp_state);
      chk({tag, ":period"}, period, exp_period);
      repeat (len - 3) tick();
   endtask

   initial begin
      int e0;
      int unlocked;
      n_checks = 0;
      n_errors = 0;
      err_cnt  = 0;
      rst = 1'b0;
      led = 1'b0;
      repeat (3) tick();

      // Reset state.
      chk("rst:level", level, 0);
      chk("rst:edge_p", edge_p, 0);
      chk("rst:period", period, 0);
      chk("rst:locked", locked, 0);
      chk("rst:err", err, 0);
      chk("rst:state", fsm_state, IDLE);
      rst = 1'b1;
      repeat (5) tick();

      // 16-cycle toggling: lock on the 4th edge.
      half_chk("acq1", 16, 0, 0, ACQ, 0);
      half_chk("acq2", 16, 0, 0, ACQ, 16);
      half_chk("acq3", 16, 0, 0, ACQ, 16);
      half_chk("acq4", 16, 0, 1, LOCK, 16);
      chk("acq:no_err", err_cnt, 0);

      // Window edges while locked, then an 18 drops lock.
      half_chk("lk16", 15, 0, 1, LOCK, 16);
      half_chk("lk15", 17, 0, 1, LOCK, 15);
      half_chk("lk17", 16, 0, 1, LOCK, 17);
      half_chk("lk16b", 18, 0, 1, LOCK, 16);
      half_chk("lk18", 16, 1, 0, ACQ, 18);
      chk("lk18:one_err", err_cnt, 1);

      // In ACQ: 14 rejected, 18 rejected, then relock.
      half_chk("aq16", 14, 0, 0, ACQ, 16);
      half_chk("aq14", 18, 1, 0, ACQ, 14);
      half_chk("aq18", 16, 1, 0, ACQ, 18);
      half_chk("re1", 16, 0, 0, ACQ, 16);
      half_chk("re2", 16, 0, 0, ACQ, 16);
      half_chk("re3", 16, 0, 1, LOCK, 16);
      chk("aq:errs", err_cnt, 3);

      // Freeze led while locked: timeout when ivl reaches 18.
      e0 = err_cnt;
      repeat (4) tick();
      chk("to:err_before", err, 0);
      chk("to:locked_before", locked, 1);
      tick();
      chk("to:err", err, 1);
      chk("to:locked", locked, 0);
      chk("to:state", fsm_state, IDLE);
      chk("to:period", period, 16);
      tick();
      chk("to:err_pulse", err, 0);
      repeat (100) tick();
      chk("to:one_err", err_cnt - e0, 1);
      chk("to:idle", fsm_state, IDLE);

      // Re-acquire from IDLE; first edge leaves period unchanged.
      half_chk("ri0", 16, 0, 0, ACQ, 16);
      half_chk("ri1", 16, 0, 0, ACQ, 16);
      half_chk("ri2", 16, 0, 0, ACQ, 16);
      half_chk("ri3", 16, 0, 1, LOCK, 16);

      // Asynchronous reset mid-LOCK clears everything at once.
      e0 = err_cnt;
      repeat (5) tick();
      #2;
      rst = 1'b0;
      led = 1'b1;
      #1;
      chk("mrst:level", level, 0);
      chk("mrst:edge_p", edge_p, 0);
      chk("mrst:period", period, 0);
      chk("mrst:locked", locked, 0);
      chk("mrst:err", err, 0);
      chk("mrst:state", fsm_state, IDLE);
      repeat (2) tick();
      rst = 1'b1;

      // led high at release gives one edge, absorbed by IDLE.
      tick();
      tick();
      chk("rel:level", level, 1);
      tick();
      chk("rel:edge_p", edge_p, 1);
      chk("rel:err", err, 0);
      chk("rel:state", fsm_state, ACQ);
      repeat (13) tick();
      half_chk("rl1", 16, 0, 0, ACQ, 16);
      half_chk("rl2", 16, 0, 0, ACQ, 16);
      half_chk("rl3", 16, 0, 1, LOCK, 16);
      chk("rl:no_err", err_cnt - e0, 0);

      // Free-running blinker after a fresh reset: lock within 5 half-periods.
      rst = 1'b0;
      led = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      e0 = err_cnt;
      unlocked = 0;
      for (int c = 0; c < 1100; c++) begin
         if (c % 16 == 0) led = ~led;
         tick();
         if (c == 80) chk("blk:locked_5half", locked, 1);
         if (c > 80 && !locked) unlocked++;
      end
      chk("blk:held", unlocked, 0);
      chk("blk:no_err", err_cnt - e0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
